bpool_binarize: RTL and testbench

BPOOL_BINARIZE -- requirements
Module: bpool_binarize

---
 rtl/bpool_binarize_pkg.sv | 19 +
 rtl/bpool_binarize_pool2x2_cmp.sv | 25 ++
 rtl/bpool_binarize.sv | 116 +++++++++++
 tb/tb_bpool_binarize.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/bpool_binarize_pkg.sv
// Shared BNN constants: conv-layer geometry and pooling/binarize defaults.
// Also holds the pooling FSM state encoding.
package bpool_binarize_pkg;

  localparam int CONV_K      = 3;
  localparam int CONV_IN_DIM = 28;
  localparam int CONV_OUT_W  = 4;

  localparam int BP_IN_DIM  = CONV_IN_DIM - CONV_K + 1;
  localparam int BP_ACC_W   = CONV_OUT_W;
  localparam int BP_OUT_DIM = BP_IN_DIM / 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_POOL,
    ST_DONE
  } bp_state_e;

endpackage

// File: rtl/bpool_binarize_pool2x2_cmp.sv
// One pooled output bit: max over a 2x2 window, then unsigned
// compare against the binarization threshold.
module pool2x2_cmp
  import bpool_binarize_pkg::*;
#(
  parameter int ACC_W = BP_ACC_W
) (
  input  logic [ACC_W-1:0] a_i,
  input  logic [ACC_W-1:0] b_i,
  input  logic [ACC_W-1:0] c_i,
  input  logic [ACC_W-1:0] d_i,
  input  logic [ACC_W-1:0] thr_i,
  output logic             bit_o
);

  logic [ACC_W-1:0] m_ab;
  logic [ACC_W-1:0] m_cd;
  logic [ACC_W-1:0] m_all;

  assign m_ab  = (a_i >= b_i) ? a_i : b_i;
  assign m_cd  = (c_i >= d_i) ? c_i : d_i;
  assign m_all = (m_ab >= m_cd) ? m_ab : m_cd;
  assign bit_o = (m_all >= thr_i);

endmodule

// File: rtl/bpool_binarize.sv
// 2x2 max-pool + threshold binarizer; emits one pooled row per
// cycle with valid/ready back-pressure and assembles the full map.
module bpool_binarize
  import bpool_binarize_pkg::*;
#(
  parameter int IN_DIM  = BP_IN_DIM,
  parameter int ACC_W   = BP_ACC_W,
  parameter int OUT_DIM = IN_DIM / 2
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [IN_DIM-1:0][IN_DIM-1:0][ACC_W-1:0] layer_i,
  input  logic [ACC_W-1:0]                       thr_i,
  input  logic                                   valid_i,
  output logic                                   ready_o,
  output logic [OUT_DIM-1:0]                     row_o,
  output logic [3:0]                             row_idx_o,
  output logic                                   row_valid_o,
  input  logic                                   row_ready_i,
  output logic [OUT_DIM-1:0][OUT_DIM-1:0]        layer_o,
  output logic                                   done_o
);

  localparam int IW = $clog2(IN_DIM);

  bp_state_e state_q, state_d;
  logic [3:0] r_q, r_d;
  logic [IN_DIM-1:0][IN_DIM-1:0][ACC_W-1:0] layer_q;
  logic [ACC_W-1:0] thr_q;
  logic [OUT_DIM-1:0] row_q, row_d;
  logic [OUT_DIM-1:0][OUT_DIM-1:0] lay_q;

  logic take_in, adv, last;
  logic [3:0] sel_r;
  logic [IW-1:0] lo, hi;
  logic [IN_DIM-1:0][ACC_W-1:0] row_a, row_b;
  logic [ACC_W-1:0] thr_s;

  assign take_in = (state_q == ST_IDLE) && valid_i;
  assign last    = (r_q == 4'(OUT_DIM - 1));
  assign adv     = (state_q == ST_POOL) && row_ready_i && !last;

  // Row 0 is pooled straight from the input so it is ready one
  // cycle after acceptance; later rows pre-compute r+1.
  assign sel_r = take_in ? 4'd0 : r_q + 4'd1;
  assign lo    = IW'(2 * int'(sel_r));
  assign hi    = lo | IW'(1);
  assign row_a = take_in ? layer_i[lo] : layer_q[lo];
  assign row_b = take_in ? layer_i[hi] : layer_q[hi];
  assign thr_s = take_in ? thr_i : thr_q;

  for (genvar c = 0; c < OUT_DIM; c++) begin : g_col
    pool2x2_cmp #(.ACC_W(ACC_W)) u_cmp (
      .a_i   (row_a[2*c]),
      .b_i   (row_a[2*c+1]),
      .c_i   (row_b[2*c]),
      .d_i   (row_b[2*c+1]),
      .thr_i (thr_s),
      .bit_o (row_d[c])
    );
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    unique case (state_q)
      ST_IDLE: begin
        if (valid_i) begin
          state_d = ST_POOL;
          r_d     = '0;
        end
      end
      ST_POOL: begin
        if (row_ready_i) begin
          if (last) state_d = ST_DONE;
          else      r_d     = r_q + 4'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      r_q     <= '0;
      layer_q <= '0;
      thr_q   <= '0;
      row_q   <= '0;
      lay_q   <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      if (take_in) begin
        layer_q <= layer_i;
        thr_q   <= thr_i;
      end
      if (take_in || adv) row_q <= row_d;
      if ((state_q == ST_POOL) && row_ready_i) lay_q[r_q] <= row_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) assert (IN_DIM % 2 == 0)
      else $error("bpool_binarize: odd IN_DIM unsupported");
  end

  assign ready_o     = (state_q == ST_IDLE);
  assign row_valid_o = (state_q == ST_POOL);
  assign done_o      = (state_q == ST_DONE);
  assign row_o       = row_q;
  assign row_idx_o   = r_q;
  assign layer_o     = lay_q;

endmodule

// File: tb/tb_bpool_binarize.sv
// Directed bench for bpool_binarize: hand-computed rows, maps,
// done timing, back-pressure hold and mid-layer reset.
module tb_bpool_binarize;

  localparam int IN = 26;
  localparam int AW = 4;
  localparam int OD = 13;

  logic clk = 1'b0;
  logic reset;
  logic [IN-1:0][IN-1:0][AW-1:0] layer_i;
  logic [AW-1:0] thr_i;
  logic valid_i;
  logic ready_o;
  logic [OD-1:0] row_o;
  logic [3:0] row_idx_o;
  logic row_valid_o;
  logic row_ready_i;
  logic [OD-1:0][OD-1:0] layer_o;
  logic done_o;

  int nerr = 0;
  int nchk = 0;

  logic [OD*OD-1:0] ones_map;
  logic [OD*OD-1:0] zero_map;
  logic [OD*OD-1:0] hot_map;

  always #5 clk = ~clk;

  bpool_binarize #(.IN_DIM(IN), .ACC_W(AW), .OUT_DIM(OD)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .layer_i     (layer_i),
    .thr_i       (thr_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .row_o       (row_o),
    .row_idx_o   (row_idx_o),
    .row_valid_o (row_valid_o),
    .row_ready_i (row_ready_i),
    .layer_o     (layer_o),
    .done_o      (done_o)
  );

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [AW-1:0] v);
    for (int i = 0; i < IN; i++)
      for (int j = 0; j < IN; j++)
        layer_i[i][j] = v;
  endtask

  // Accept one layer, drain it, check every row, done timing and map.
  task automatic do_layer(input string tag, input logic [AW-1:0] thr,
                          input bit tog, input logic [OD*OD-1:0] exp,
                          input int exp_done);
    int idx;
    bit seen;
    bit stalled;
    logic [OD-1:0] prow;
    logic [3:0] pidx;
    idx = 0;
    seen = 0;
    stalled = 0;
    prow = '0;
    pidx = '0;
    chk({tag, "_ready"}, ready_o, 1);
    thr_i = thr;
    valid_i = 1'b1;
    row_ready_i = 1'b1;
    step();
    // Scramble inputs while busy; captured copy must be used.
    layer_i = ~layer_i;
    thr_i = ~thr;
    for (int k = 1; k <= 60 && !seen; k++) begin
      if (stalled) begin
        chk({tag, "_hold_row"}, row_o, prow);
        chk({tag, "_hold_idx"}, row_idx_o, pidx);
        chk({tag, "_hold_vld"}, row_valid_o, 1);
      end
      if (done_o) begin
        seen = 1;
        valid_i = 1'b0;
        chk({tag, "_done_cyc"}, k, exp_done);
        chk({tag, "_nrows"}, idx, OD);
        chk({tag, "_vld_in_done"}, row_valid_o, 0);
      end else begin
        row_ready_i = tog ? ((k % 2) == 1) : 1'b1;
        if (row_valid_o && row_ready_i) begin
          chk({tag, "_idx"}, row_idx_o, idx);
          chk({tag, "_row"}, row_o, exp[idx*OD +: OD]);
          idx++;
          stalled = 0;
        end else begin
          stalled = row_valid_o;
          prow = row_o;
          pidx = row_idx_o;
        end
        step();
      end
    end
    chk({tag, "_done_seen"}, seen, 1);
    valid_i = 1'b0;
    row_ready_i = 1'b1;
    step();
    chk({tag, "_layer"}, layer_o, exp);
    chk({tag, "_done_pulse"}, done_o, 0);
    chk({tag, "_ready_after"}, ready_o, 1);
  endtask

  initial begin
    bit sawdone;
    ones_map = '1;
    zero_map = '0;
    hot_map = '0;
    hot_map[1*OD + 2] = 1'b1;

    // Reset wins over a simultaneous valid_i.
    reset = 1'b1;
    valid_i = 1'b1;
    row_ready_i = 1'b1;
    thr_i = '0;
    fill(4'd9);
    step();
    step();
    chk("rst_ready", ready_o, 1);
    chk("rst_rvalid", row_valid_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_row", row_o, 0);
    chk("rst_idx", row_idx_o, 0);
    chk("rst_layer", layer_o, 0);
    valid_i = 1'b0;
    reset = 1'b0;
    step();

    fill(4'd9);
    do_layer("all9_t5", 4'd5, 1'b0, ones_map, 14);

    for (int i = 0; i < IN; i++)
      for (int j = 0; j < IN; j++)
        layer_i[i][j] = ((i % 2 == 0) && ((j % 2) == ((i/2 + j/2) % 2)))
                        ? 4'd9 : 4'd0;
    do_layer("checker", 4'd5, 1'b0, ones_map, 14);

    fill(4'd4);
    do_layer("all4_t5", 4'd5, 1'b0, zero_map, 14);

    fill(4'd0);
    layer_i[3][5] = 4'd7;
    do_layer("hotpix", 4'd6, 1'b0, hot_map, 14);

    fill(4'd9);
    do_layer("toggle", 4'd5, 1'b1, ones_map, 26);

    fill(4'd0);
    do_layer("thr0", 4'd0, 1'b0, ones_map, 14);

    fill(4'd9);
    do_layer("thr15", 4'd15, 1'b0, zero_map, 14);

    // Abandon a layer at row 6 via reset.
    fill(4'd9);
    thr_i = 4'd5;
    valid_i = 1'b1;
    row_ready_i = 1'b1;
    step();
    valid_i = 1'b0;
    repeat (6) step();
    chk("mid_idx6", row_idx_o, 6);
    chk("mid_layer_partial", layer_o, {{(7*OD){1'b0}}, {(6*OD){1'b1}}});
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rvalid", row_valid_o, 0);
    chk("mid_layer", layer_o, 0);
    chk("mid_ready", ready_o, 1);
    sawdone = 0;
    repeat (20) begin
      if (done_o) sawdone = 1;
      step();
    end
    chk("mid_no_done", sawdone, 0);

    fill(4'd9);
    do_layer("after_rst", 4'd5, 1'b0, ones_map, 14);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
